shift_deserializer: RTL and testbench

- Downstream consumer of the N-bit shift register's serial output.
- Reassembles N-bit words from a serial bit stream qualified by a valid strobe, in either bit order.
- Buffers completed words in a small FIFO and presents them on a valid/ready interface.
- Overflow (word completes while the FIFO is full) is flagged sticky.

---
 rtl/shift_deserializer_pkg.sv | 17 +
 rtl/shift_deserializer_fifo.sv | 73 +++++++
 rtl/shift_deserializer.sv | 123 ++++++++++++
 tb/tb_shift_deserializer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_deserializer_pkg.sv
// Shared definitions for the serial-to-parallel deserializer.
// Holds the default word width and FIFO depth, the bit-counter width
// for the default word width, and the framing FSM state encoding.
package shift_deserializer_pkg;

  localparam int N_DEF     = 8;
  localparam int DEPTH_DEF = 2;
  localparam int CNT_W     = $clog2(N_DEF);

  // IDLE: no bits of the current frame collected yet.
  // SHIFT: a frame is partially assembled.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/shift_deserializer_fifo.sv
// deser_fifo: small synchronous FIFO that buffers completed words.
// Ports:
//   clk, rst        - clock; synchronous active-low reset
//   push, din       - write request and data (dropped when full with no pop)
//   pop             - read request (ignored when empty)
//   dout            - registered head word (0 after reset)
//   dout_valid      - FIFO non-empty
//   full            - FIFO holds DEPTH words
module deser_fifo
  import shift_deserializer_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [N-1:0] din,
  input  logic         pop,
  output logic [N-1:0] dout,
  output logic         dout_valid,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [N-1:0]  head;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign empty      = (count == '0);
  assign full       = (count == (AW+1)'(DEPTH));
  assign do_pop     = pop && !empty;
  // A full FIFO still accepts a push when a pop frees a slot at the same edge.
  assign do_push    = push && (!full || do_pop);
  assign dout       = head;
  assign dout_valid = !empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // The head register tracks what mem[rd_ptr] will hold after this edge.
      // An incoming word becomes the head when it is the only word left.
      if (do_push && (empty || (count == (AW+1)'(1) && do_pop)))
        head <= din;
      else if (do_pop)
        head <= mem[rd_ptr + AW'(1)];
    end
  end

  // NOTE: the storage array has no reset; validity is carried entirely by
  // count, so clearing it would only add reset fan-out for no benefit.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/shift_deserializer.sv
// shift_deserializer: reassembles N-bit words from a strobed serial stream,
// in MSB-first or LSB-first order, and queues them in a small FIFO.
// Ports:
//   clk, rst        - clock; synchronous active-low reset
//   sin, sin_valid  - serial bit and its qualifier
//   sync            - frame-align pulse, discards any partial word
//   msb_first       - bit order, latched on the first bit of each frame
//   dout, dout_valid, dout_ready - valid/ready word output
//   bit_cnt         - bits collected in the current frame
//   overflow        - sticky: a completed word was dropped (FIFO full)
//   clr_ovf         - clears overflow (a same-cycle new overflow wins)
module shift_deserializer
  import shift_deserializer_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sin,
  input  logic                 sin_valid,
  input  logic                 sync,
  input  logic                 msb_first,
  output logic [N-1:0]         dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [$clog2(N)-1:0] bit_cnt,
  output logic                 overflow,
  input  logic                 clr_ovf
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         state;
  state_t         state_nxt;
  logic [N-1:0]   shreg;
  logic [N-1:0]   base;
  logic [N-1:0]   shifted;
  logic [CW-1:0]  cnt;
  logic           frame_msb;
  logic           first_bit;
  logic           eff_msb;
  logic           complete;
  logic           fifo_full;
  logic           pop;
  logic           ovf_event;

  assign bit_cnt = cnt;
  assign pop     = dout_valid && dout_ready;

  // State register.
  // NOTE: sequential blocks use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    if (sin_valid) begin
      if (sync || state == IDLE) state_nxt = SHIFT;
      else if (cnt == LAST)      state_nxt = IDLE;
    end else if (sync) begin
      state_nxt = IDLE;
    end
  end

  // Output / datapath decode.
  always_comb begin
    // sync restarts framing, so a coincident bit opens a new frame.
    first_bit = sin_valid && (state == IDLE || sync);
    eff_msb   = first_bit ? msb_first : frame_msb;
    base      = sync ? '0 : shreg;
    shifted   = eff_msb ? {base[N-2:0], sin} : {sin, base[N-1:1]};
    complete  = sin_valid && !sync && (cnt == LAST);
    ovf_event = complete && fifo_full && !pop;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg     <= '0;
      cnt       <= '0;
      frame_msb <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (first_bit) frame_msb <= msb_first;

      if (complete) begin
        shreg <= '0;
        cnt   <= '0;
      end else if (sin_valid) begin
        shreg <= shifted;
        cnt   <= (sync ? '0 : cnt) + CW'(1);
      end else if (sync) begin
        shreg <= '0;
        cnt   <= '0;
      end

      if (ovf_event)    overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  deser_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (complete),
    .din        (shifted),
    .pop        (pop),
    .dout       (dout),
    .dout_valid (dout_valid),
    .full       (fifo_full)
  );

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed testbench for shift_deserializer (N=8, DEPTH=2).
module tb_shift_deserializer;
  import shift_deserializer_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             sin;
  logic             sin_valid;
  logic             sync;
  logic             msb_first;
  logic [7:0]       dout;
  logic             dout_valid;
  logic             dout_ready;
  logic [CNT_W-1:0] bit_cnt;
  logic             overflow;
  logic             clr_ovf;

  int n_pass  = 0;
  int n_total = 0;

  shift_deserializer #(.N(8), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sync       (sync),
    .msb_first  (msb_first),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .bit_cnt    (bit_cnt),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  always #5 clk = ~clk;

  // Advance one clock edge; outputs are read 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sin       = b;
    sin_valid = 1'b1;
    step();
    sin_valid = 1'b0;
    sin       = 1'b0;
  endtask

  // Sends a word MSB-first (msb_first=1 set by caller for frame order).
  task automatic send_word_msb(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic drain_one();
    dout_ready = 1'b1;
    step();
    dout_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sin        = 1'($urandom);
      sin_valid  = 1'($urandom);
      sync       = 1'($urandom);
      msb_first  = 1'($urandom);
      dout_ready = 1'($urandom);
      clr_ovf    = 1'($urandom);
      step();
    end
    sin = 0; sin_valid = 0; sync = 0; msb_first = 0; dout_ready = 0; clr_ovf = 0;
    n_total++;
    if ({dout, dout_valid, bit_cnt, overflow} !== 13'd0) begin
      $display("FAIL reset: dout=%h valid=%b cnt=%0d ovf=%b, required all 0",
               dout, dout_valid, bit_cnt, overflow);
    end else n_pass++;
    rst = 1'b1;
    step();
    n_total++;
    if (dout_valid !== 1'b0 || bit_cnt !== 3'd0) begin
      $display("FAIL reset_release: valid=%b cnt=%0d, required 0/0", dout_valid, bit_cnt);
    end else n_pass++;
  endtask

  task automatic test_msb_word();
    logic [7:0] pat;
    pat = 8'hA5;
    msb_first = 1'b1;
    for (int i = 7; i >= 1; i--) send_bit(pat[i]);
    n_total++;
    if (dout_valid !== 1'b0 || bit_cnt !== 3'd7) begin
      $display("FAIL msb_before_last: valid=%b cnt=%0d, required 0/7", dout_valid, bit_cnt);
    end else n_pass++;
    send_bit(pat[0]);
    n_total++;
    if (dout_valid !== 1'b1 || dout !== 8'hA5 || bit_cnt !== 3'd0) begin
      $display("FAIL msb_word: valid=%b dout=%h cnt=%0d, required 1/a5/0",
               dout_valid, dout, bit_cnt);
    end else n_pass++;
    drain_one();
    n_total++;
    if (dout_valid !== 1'b0) begin
      $display("FAIL msb_drain: valid=%b, required 0", dout_valid);
    end else n_pass++;
  endtask

  task automatic test_lsb_gaps();
    logic [7:0] seq_a;
    logic [7:0] seq_b;
    seq_a = 8'b1010_0101;  // bit sequence in send order, index 7 first
    seq_b = 8'b1100_0000;
    msb_first = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_bit(seq_a[7-i]);
      if (i == 2) msb_first = 1'b1;  // must be ignored mid-frame
      step();                         // idle gap cycle
    end
    n_total++;
    if (dout_valid !== 1'b1 || dout !== 8'hA5) begin
      $display("FAIL lsb_word_a5: valid=%b dout=%h, required 1/a5", dout_valid, dout);
    end else n_pass++;
    drain_one();
    msb_first = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_bit(seq_b[7-i]);
      step();
    end
    n_total++;
    if (dout_valid !== 1'b1 || dout !== 8'h03) begin
      $display("FAIL lsb_word_03: valid=%b dout=%h, required 1/03", dout_valid, dout);
    end else n_pass++;
    drain_one();
  endtask

  task automatic test_sync();
    msb_first = 1'b1;
    send_bit(1); send_bit(0); send_bit(1); send_bit(1); send_bit(0);
    sync = 1'b1;
    step();
    sync = 1'b0;
    n_total++;
    if (bit_cnt !== 3'd0 || dout_valid !== 1'b0) begin
      $display("FAIL sync_discard: cnt=%0d valid=%b, required 0/0", bit_cnt, dout_valid);
    end else n_pass++;
    send_word_msb(8'hFF);
    n_total++;
    if (dout_valid !== 1'b1 || dout !== 8'hFF) begin
      $display("FAIL sync_ff: valid=%b dout=%h, required 1/ff", dout_valid, dout);
    end else n_pass++;
    drain_one();
    n_total++;
    if (dout_valid !== 1'b0) begin
      $display("FAIL sync_single_word: valid=%b, required 0", dout_valid);
    end else n_pass++;

    // sync coincident with a bit, both orders; a partial frame precedes it.
    for (int o = 1; o >= 0; o--) begin
      msb_first = 1'(o);
      send_bit(0); send_bit(1); send_bit(1);
      msb_first = 1'(o);
      sync = 1'b1;
      send_bit(1);
      sync = 1'b0;
      n_total++;
      if (bit_cnt !== 3'd1) begin
        $display("FAIL sync_bit_cnt: cnt=%0d, required 1", bit_cnt);
      end else n_pass++;
      msb_first = 1'(!o);  // ignored mid-frame
      for (int i = 0; i < 7; i++) send_bit(0);
      n_total++;
      if (dout_valid !== 1'b1 || dout !== ((o == 1) ? 8'h80 : 8'h01)) begin
        $display("FAIL sync_bit0_order%0d: valid=%b dout=%h, required 1/%h",
                 o, dout_valid, dout, (o == 1) ? 8'h80 : 8'h01);
      end else n_pass++;
      drain_one();
    end
  endtask

  task automatic test_overflow();
    msb_first  = 1'b1;
    dout_ready = 1'b0;
    send_word_msb(8'h11);
    send_word_msb(8'h22);
    n_total++;
    if (overflow !== 1'b0 || dout !== 8'h11) begin
      $display("FAIL ovf_full_no_ovf: ovf=%b dout=%h, required 0/11", overflow, dout);
    end else n_pass++;
    send_word_msb(8'h33);
    n_total++;
    if (overflow !== 1'b1 || dout !== 8'h11 || dout_valid !== 1'b1) begin
      $display("FAIL ovf_set: ovf=%b dout=%h valid=%b, required 1/11/1",
               overflow, dout, dout_valid);
    end else n_pass++;
    drain_one();
    n_total++;
    if (dout_valid !== 1'b1 || dout !== 8'h22) begin
      $display("FAIL ovf_pop2: valid=%b dout=%h, required 1/22", dout_valid, dout);
    end else n_pass++;
    drain_one();
    n_total++;
    if (dout_valid !== 1'b0 || overflow !== 1'b1) begin
      $display("FAIL ovf_empty_sticky: valid=%b ovf=%b, required 0/1", dout_valid, overflow);
    end else n_pass++;
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    n_total++;
    if (overflow !== 1'b0) begin
      $display("FAIL ovf_clear: ovf=%b, required 0", overflow);
    end else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    w = 8'h33;
    msb_first  = 1'b1;
    dout_ready = 1'b0;
    send_word_msb(8'h11);
    send_word_msb(8'h22);
    for (int i = 7; i >= 1; i--) send_bit(w[i]);
    n_total++;
    if (dout !== 8'h11 || dout_valid !== 1'b1) begin
      $display("FAIL b2b_head11: dout=%h valid=%b, required 11/1", dout, dout_valid);
    end else n_pass++;
    dout_ready = 1'b1;
    send_bit(w[0]);
    n_total++;
    if (overflow !== 1'b0 || dout !== 8'h22) begin
      $display("FAIL b2b_pop_push: ovf=%b dout=%h, required 0/22", overflow, dout);
    end else n_pass++;
    step();
    n_total++;
    if (dout !== 8'h33 || dout_valid !== 1'b1) begin
      $display("FAIL b2b_head33: dout=%h valid=%b, required 33/1", dout, dout_valid);
    end else n_pass++;
    step();
    dout_ready = 1'b0;
    n_total++;
    if (dout_valid !== 1'b0) begin
      $display("FAIL b2b_empty: valid=%b, required 0", dout_valid);
    end else n_pass++;

    // Reset in the middle of a frame.
    send_bit(1); send_bit(1); send_bit(1); send_bit(1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    n_total++;
    if (bit_cnt !== 3'd0 || dout_valid !== 1'b0 || dout !== 8'h00) begin
      $display("FAIL midframe_reset: cnt=%0d valid=%b dout=%h, required 0/0/00",
               bit_cnt, dout_valid, dout);
    end else n_pass++;
    send_word_msb(8'h5A);
    n_total++;
    if (dout_valid !== 1'b1 || dout !== 8'h5A) begin
      $display("FAIL post_reset_word: valid=%b dout=%h, required 1/5a", dout_valid, dout);
    end else n_pass++;
    drain_one();
  endtask

  initial begin
    test_reset();
    test_msb_word();
    test_lsb_gaps();
    test_sync();
    test_overflow();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
